// File: rtl/player_move_ctrl.sv
// Initiator side of the player-move handshake: turns direction key pulses into
// a move request, waits for the responder, and owns the player position/state.
module player_move_ctrl #(
  parameter int MAP_WIDTH  = 11,
  parameter int MAP_HEIGHT = 11,
  parameter int START_X    = 5,
  parameter int START_Y    = 10,
  parameter int START_KEYS = 0,
  parameter int TIMEOUT    = 15,
  parameter int COOLDOWN   = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic       player_ask_move,
  output logic [3:0] player_ask_x,
  output logic [3:0] player_ask_y,
  input  logic       accept_move,
  input  logic [3:0] goto_x,
  input  logic [3:0] goto_y,
  input  logic [3:0] key_num_in,
  output logic [3:0] player_x,
  output logic [3:0] player_y,
  output logic [3:0] key_num,
  output logic [1:0] facing,
  output logic       busy,
  output logic       timeout_err
);

  localparam int TW = (TIMEOUT  > 1) ? $clog2(TIMEOUT + 1)  : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_COOLDOWN
  } state_t;

  state_t        state_q;
  logic [3:0]    x_q, y_q, keys_q, ask_x_q, ask_y_q;
  logic [1:0]    facing_q;
  logic          ask_move_q, busy_q, terr_q;
  logic [TW-1:0] wait_cnt_q;
  logic [CW-1:0] cool_cnt_q;

  logic          key_any;
  logic          blocked_d;
  logic [1:0]    dir_d;
  logic [3:0]    tgt_x_d, tgt_y_d;

  // Boundary test precedes the +/-1 so the 4-bit target never wraps.
  always_comb begin
    key_any   = key_up | key_down | key_left | key_right;
    dir_d     = facing_q;
    blocked_d = 1'b0;
    tgt_x_d   = x_q;
    tgt_y_d   = y_q;
    if (key_up) begin
      dir_d     = 2'd0;
      blocked_d = (y_q == 4'd0);
      if (!blocked_d) tgt_y_d = y_q - 4'd1;
    end else if (key_down) begin
      dir_d     = 2'd1;
      blocked_d = (y_q >= 4'(MAP_HEIGHT - 1));
      if (!blocked_d) tgt_y_d = y_q + 4'd1;
    end else if (key_left) begin
      dir_d     = 2'd2;
      blocked_d = (x_q == 4'd0);
      if (!blocked_d) tgt_x_d = x_q - 4'd1;
    end else if (key_right) begin
      dir_d     = 2'd3;
      blocked_d = (x_q >= 4'(MAP_WIDTH - 1));
      if (!blocked_d) tgt_x_d = x_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      x_q        <= 4'(START_X);
      y_q        <= 4'(START_Y);
      keys_q     <= 4'(START_KEYS);
      ask_x_q    <= 4'(START_X);
      ask_y_q    <= 4'(START_Y);
      facing_q   <= 2'd0;
      ask_move_q <= 1'b0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      wait_cnt_q <= '0;
      cool_cnt_q <= '0;
    end else begin
      ask_move_q <= 1'b0;
      terr_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (key_any) begin
            facing_q <= dir_d;
            busy_q   <= 1'b1;
            if (blocked_d) begin
              cool_cnt_q <= '0;
              state_q    <= S_COOLDOWN;
            end else begin
              ask_x_q    <= tgt_x_d;
              ask_y_q    <= tgt_y_d;
              ask_move_q <= 1'b1;
              state_q    <= S_REQUEST;
            end
          end
        end
        S_REQUEST: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // An accept on the final wait cycle still commits the move.
          if (accept_move) begin
            x_q        <= goto_x;
            y_q        <= goto_y;
            keys_q     <= key_num_in;
            cool_cnt_q <= '0;
            state_q    <= S_COOLDOWN;
          end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
            terr_q     <= 1'b1;
            cool_cnt_q <= '0;
            state_q    <= S_COOLDOWN;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (cool_cnt_q == CW'(COOLDOWN - 1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cool_cnt_q <= cool_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign player_ask_move = ask_move_q;
  assign player_ask_x    = ask_x_q;
  assign player_ask_y    = ask_y_q;
  assign player_x        = x_q;
  assign player_y        = y_q;
  assign key_num         = keys_q;
  assign facing          = facing_q;
  assign busy            = busy_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed plus randomized moves against a behavioural model of the player
// position, facing, key count and handshake timing.
module tb_player_move_ctrl;

  localparam int W  = 11;
  localparam int H  = 11;
  localparam int SX = 5;
  localparam int SY = 10;
  localparam int SK = 0;
  localparam int TO = 15;
  localparam int CD = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key_up, key_down, key_left, key_right;
  logic       player_ask_move;
  logic [3:0] player_ask_x, player_ask_y;
  logic       accept_move;
  logic [3:0] goto_x, goto_y, key_num_in;
  logic [3:0] player_x, player_y, key_num;
  logic [1:0] facing;
  logic       busy, timeout_err;

  int vectors = 0;
  int errors  = 0;
  int mx, my, mk, mf;

  always #5 clk = ~clk;

  player_move_ctrl #(
    .MAP_WIDTH (W),
    .MAP_HEIGHT(H),
    .START_X   (SX),
    .START_Y   (SY),
    .START_KEYS(SK),
    .TIMEOUT   (TO),
    .COOLDOWN  (CD)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .key_up         (key_up),
    .key_down       (key_down),
    .key_left       (key_left),
    .key_right      (key_right),
    .player_ask_move(player_ask_move),
    .player_ask_x   (player_ask_x),
    .player_ask_y   (player_ask_y),
    .accept_move    (accept_move),
    .goto_x         (goto_x),
    .goto_y         (goto_y),
    .key_num_in     (key_num_in),
    .player_x       (player_x),
    .player_y       (player_y),
    .key_num        (key_num),
    .facing         (facing),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".x"}, 32'(player_x), mx);
    chk({tag, ".y"}, 32'(player_y), my);
    chk({tag, ".keys"}, 32'(key_num), mk);
    chk({tag, ".facing"}, 32'(facing), mf);
  endtask

  // Runs until busy drops; optionally throws a stray key and accept into the first cycle.
  task automatic wait_idle(input bit inject, output int n, output int terr_n, output int asks);
    n = 0; terr_n = 0; asks = 0;
    while (busy === 1'b1 && n < 400) begin
      if (inject && n == 0) begin
        key_down    = 1'b1;
        accept_move = 1'b1;
        goto_x      = 4'($urandom_range(0, W - 1));
        goto_y      = 4'($urandom_range(0, H - 1));
        key_num_in  = 4'($urandom_range(0, 15));
      end
      tick;
      key_down    = 1'b0;
      accept_move = 1'b0;
      n++;
      if (timeout_err === 1'b1) terr_n++;
      if (player_ask_move === 1'b1) asks++;
    end
  endtask

  // delay < 0: responder silent; gx < 0: responder returns the requested tile.
  task automatic do_move(input bit u, input bit d, input bit l, input bit r,
                         input int delay, input int gx, input int gy, input int gk,
                         input bit inject, input string tag);
    int dir, nx, ny, n, tn, asks;
    bit blk;
    nx = mx; ny = my;
    if (u)      begin dir = 0; ny = my - 1; end
    else if (d) begin dir = 1; ny = my + 1; end
    else if (l) begin dir = 2; nx = mx - 1; end
    else        begin dir = 3; nx = mx + 1; end
    blk = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
    mf = dir;
    if (gx < 0) begin gx = nx; gy = ny; end

    key_up = u; key_down = d; key_left = l; key_right = r;
    tick;
    key_up = 0; key_down = 0; key_left = 0; key_right = 0;
    chk({tag, ".facing"}, 32'(facing), mf);
    chk({tag, ".busy"}, 32'(busy), 1);

    if (blk) begin
      chk({tag, ".no_ask"}, 32'(player_ask_move), 0);
      wait_idle(inject, n, tn, asks);
      chk({tag, ".cool_len"}, n, CD);
      chk({tag, ".asks"}, asks, 0);
      chk({tag, ".terr"}, tn, 0);
    end else begin
      chk({tag, ".ask"}, 32'(player_ask_move), 1);
      chk({tag, ".ask_x"}, 32'(player_ask_x), nx);
      chk({tag, ".ask_y"}, 32'(player_ask_y), ny);
      tick;
      chk({tag, ".ask_once"}, 32'(player_ask_move), 0);
      if (delay < 0) begin
        for (int k = 1; k <= TO; k++) begin
          if (inject && k == 1) key_down = 1'b1;
          tick;
          key_down = 1'b0;
          chk({tag, ".terr_t"}, 32'(timeout_err), (k == TO) ? 1 : 0);
        end
        chk({tag, ".hold_x"}, 32'(player_ask_x), nx);
        chk({tag, ".hold_y"}, 32'(player_ask_y), ny);
        wait_idle(1'b1, n, tn, asks);
        chk({tag, ".cool_len"}, n, CD);
        chk({tag, ".terr_again"}, tn, 0);
      end else begin
        for (int k = 1; k < delay; k++) begin
          if (inject && k == 1) key_down = 1'b1;
          tick;
          key_down = 1'b0;
        end
        chk({tag, ".hold_x"}, 32'(player_ask_x), nx);
        chk({tag, ".hold_y"}, 32'(player_ask_y), ny);
        accept_move = 1'b1;
        goto_x = 4'(gx); goto_y = 4'(gy); key_num_in = 4'(gk);
        tick;
        accept_move = 1'b0;
        goto_x = 4'($urandom); goto_y = 4'($urandom); key_num_in = 4'($urandom);
        mx = gx; my = gy; mk = gk;
        chk({tag, ".no_terr"}, 32'(timeout_err), 0);
        check_state({tag, ".commit"});
        wait_idle(inject, n, tn, asks);
        chk({tag, ".cool_len"}, n, CD);
        chk({tag, ".terr"}, tn, 0);
      end
      chk({tag, ".asks"}, asks, 0);
    end
    check_state({tag, ".end"});
    chk({tag, ".idle"}, 32'(busy), 0);
  endtask

  initial begin
    int m, sel, dl, gx, gy;
    rstn = 1'b0;
    key_up = 0; key_down = 0; key_left = 0; key_right = 0;
    accept_move = 0; goto_x = 0; goto_y = 0; key_num_in = 0;
    mx = SX; my = SY; mk = SK; mf = 0;
    tick; tick; tick;
    check_state("rst");
    chk("rst.ask_x", 32'(player_ask_x), SX);
    chk("rst.ask_y", 32'(player_ask_y), SY);
    chk("rst.ask", 32'(player_ask_move), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.terr", 32'(timeout_err), 0);
    rstn = 1'b1;
    tick;

    do_move(1, 0, 0, 0, 3, 5, 9, 0, 0, "up");
    do_move(0, 0, 1, 0, 2, 0, 3, 0, 1, "tp03");
    do_move(0, 0, 1, 0, 1, 0, 0, 0, 1, "blk_left");
    do_move(0, 1, 0, 0, 4, 5, 5, 0, 0, "tp55");
    do_move(1, 0, 0, 1, 3, 5, 4, 0, 0, "up_right");
    do_move(0, 0, 0, 1, 5, mx, my, 1, 0, "wall");
    do_move(0, 0, 1, 0, -1, 0, 0, 0, 1, "silent");
    do_move(0, 1, 0, 0, TO, 5, 5, 2, 1, "last_cycle");
    do_move(0, 0, 0, 1, 1, W - 1, 0, 3, 0, "tp_corner");
    do_move(1, 0, 0, 0, 1, 0, 0, 0, 0, "blk_up");
    do_move(0, 0, 0, 1, 1, 0, 0, 0, 0, "blk_right");

    for (int i = 0; i < 40; i++) begin
      m   = $urandom_range(1, 15);
      sel = $urandom_range(0, 9);
      dl  = (sel == 0) ? -1 : $urandom_range(1, TO);
      if (sel < 7) begin
        gx = -1; gy = -1;
      end else begin
        gx = (sel == 7) ? 0 : $urandom_range(0, W - 1);
        gy = (sel == 8) ? H - 1 : $urandom_range(0, H - 1);
      end
      do_move(m[3], m[2], m[1], m[0], dl, gx, gy, $urandom_range(0, 15),
              1'($urandom_range(0, 1)), "rnd");
    end

    do_move(1, 0, 0, 0, 2, 5, 5, 4, 0, "pre_rst");
    key_up = 1'b1;
    tick;
    key_up = 1'b0;
    tick;
    tick;
    rstn = 1'b0;
    #1;
    mx = SX; my = SY; mk = SK; mf = 0;
    check_state("mid_rst");
    chk("mid_rst.busy", 32'(busy), 0);
    chk("mid_rst.ask_x", 32'(player_ask_x), SX);
    chk("mid_rst.ask_y", 32'(player_ask_y), SY);
    tick;
    rstn = 1'b1;
    tick;
    accept_move = 1'b1; goto_x = 4'd1; goto_y = 4'd1; key_num_in = 4'd7;
    tick;
    accept_move = 1'b0;
    tick;
    check_state("stray_acc");
    chk("stray_acc.busy", 32'(busy), 0);
    chk("stray_acc.ask", 32'(player_ask_move), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
